// File: rtl/rc5_pkg.sv
// rtl/rc5_pkg.sv - RC5 shared types: FSM encoding, ALU modes, table sizing, rotate helpers
package rc5_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Widest word the rotate helpers handle; callers cast the result back to W.
    localparam int RC5_MAX_W = 64;

    typedef enum logic [1:0] {
        ALU_ENC_ADD   = 2'd0,
        ALU_ENC_ROUND = 2'd1,
        ALU_DEC_SUB   = 2'd2,
        ALU_DEC_ROUND = 2'd3
    } alu_mode_e;

    function automatic int rc5_t(input int r);
        return 2 * (r + 1);
    endfunction

    function automatic logic [RC5_MAX_W-1:0] width_mask(input int width);
        logic [RC5_MAX_W-1:0] mask;
        mask = '1;
        if (width < RC5_MAX_W)
            mask = mask >> (RC5_MAX_W - width);
        return mask;
    endfunction

    function automatic logic [RC5_MAX_W-1:0] rotl(input logic [RC5_MAX_W-1:0] word,
                                                  input int width, input int amount);
        logic [RC5_MAX_W-1:0] mask;
        logic [RC5_MAX_W-1:0] w;
        mask = width_mask(width);
        w    = word & mask;
        return ((w << amount) | (w >> (width - amount))) & mask;
    endfunction

    function automatic logic [RC5_MAX_W-1:0] rotr(input logic [RC5_MAX_W-1:0] word,
                                                  input int width, input int amount);
        logic [RC5_MAX_W-1:0] mask;
        logic [RC5_MAX_W-1:0] w;
        mask = width_mask(width);
        w    = word & mask;
        return ((w >> amount) | (w << (width - amount))) & mask;
    endfunction

endpackage

// File: rtl/rc5_round_alu.sv
// rtl/rc5_round_alu.sv - RC5 half-round datapath; decrypt modes only with RC5_DECRYPT_EN
module rc5_round_alu
    import rc5_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] s,
    input  alu_mode_e    mode,
    output logic [W-1:0] result
);

    localparam int W_BITS = $clog2(W);

    logic [W_BITS-1:0] amt;
    assign amt = y[W_BITS-1:0];

    always_comb begin
        result = x + s;
        case (mode)
            ALU_ENC_ROUND: result = W'(rotl(RC5_MAX_W'(x ^ y), W, 32'(amt))) + s;
`ifdef RC5_DECRYPT_EN
            ALU_DEC_SUB:   result = x - s;
            ALU_DEC_ROUND: result = W'(rotr(RC5_MAX_W'(x - s), W, 32'(amt))) ^ y;
`endif
            default:       result = x + s;
        endcase
    end

endmodule

// File: rtl/rc5_block_cipher.sv
// rtl/rc5_block_cipher.sv - RC5-W/R block engine reading S through S_RAM port B; RC5_DECRYPT_EN adds decrypt
module rc5_block_cipher
    import rc5_pkg::*;
#(
    parameter int W = 32,
    parameter int R = 12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           iKeyReady,
    input  logic                           iStart,
    input  logic [W-1:0]                   iA,
    input  logic [W-1:0]                   iB,
`ifdef RC5_DECRYPT_EN
    input  logic                           iDecrypt,
`endif
    input  logic [W-1:0]                   iS_sub_i,
    output logic [$clog2(rc5_t(R))-1:0]    oS_address,
    output logic [W-1:0]                   oA,
    output logic [W-1:0]                   oB,
    output logic                           oBusy,
    output logic                           oValid
);

    localparam int T        = rc5_t(R);
    localparam int T_LENGTH = $clog2(T);
    localparam int K_W      = $clog2(T + 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(T);

    logic [1:0]          state;
    logic [W-1:0]        a;
    logic [W-1:0]        b;
    logic [K_W-1:0]      k;
    logic                update_a;
    logic                first_step;
    alu_mode_e           alu_mode;
    logic [W-1:0]        alu_x;
    logic [W-1:0]        alu_y;
    logic [W-1:0]        alu_out;
    logic [W-1:0]        a_next;
    logic [W-1:0]        b_next;
    logic [T_LENGTH-1:0] next_addr;
    logic [T_LENGTH-1:0] first_addr;

`ifdef RC5_DECRYPT_EN
    logic dec;
    assign first_addr = iDecrypt ? T_LENGTH'(T - 1) : '0;
`else
    localparam logic dec = 1'b0;
    assign first_addr = '0;
`endif

    // T is even, so k parity alone picks the half: encrypt updates A on odd k, decrypt on even k.
    always_comb begin
        update_a   = k[0] ^ dec;
        first_step = dec ? (k >= K_LAST - K_W'(1)) : (k <= K_W'(2));
        if (dec)
            alu_mode = first_step ? ALU_DEC_SUB : ALU_DEC_ROUND;
        else
            alu_mode = first_step ? ALU_ENC_ADD : ALU_ENC_ROUND;
        alu_x  = update_a ? a : b;
        alu_y  = update_a ? b : a;
        a_next = update_a ? alu_out : a;
        b_next = update_a ? b : alu_out;
`ifdef RC5_DECRYPT_EN
        next_addr = dec ? T_LENGTH'(T - 1) - T_LENGTH'(k) : T_LENGTH'(k);
`else
        next_addr = T_LENGTH'(k);
`endif
    end

    rc5_round_alu #(.W(W)) u_alu (
        .x      (alu_x),
        .y      (alu_y),
        .s      (iS_sub_i),
        .mode   (alu_mode),
        .result (alu_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            a          <= '0;
            b          <= '0;
            k          <= '0;
            oS_address <= '0;
            oA         <= '0;
            oB         <= '0;
            oBusy      <= 1'b0;
            oValid     <= 1'b0;
`ifdef RC5_DECRYPT_EN
            dec        <= 1'b0;
`endif
        end else begin
            oValid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iStart && iKeyReady) begin
                        a          <= iA;
                        b          <= iB;
                        k          <= K_W'(1);
                        oS_address <= first_addr;
                        oBusy      <= 1'b1;
                        state      <= ST_RUN;
`ifdef RC5_DECRYPT_EN
                        dec        <= iDecrypt;
`endif
                    end
                end
                ST_RUN: begin
                    // Losing the key mid-block means the S table is being rewritten: drop the block.
                    if (!iKeyReady) begin
                        oBusy <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        a <= a_next;
                        b <= b_next;
                        if (k == K_LAST) begin
                            oA     <= a_next;
                            oB     <= b_next;
                            oValid <= 1'b1;
                            oBusy  <= 1'b0;
                            state  <= ST_DONE;
                        end else begin
                            k          <= k + K_W'(1);
                            oS_address <= next_addr;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_block_cipher.sv
// tb/tb_rc5_block_cipher.sv - directed bench for rc5_block_cipher against published RC5-32/12/16 vectors
module tb_rc5_block_cipher;

    logic        clk;
    logic        rst;
    logic        iKeyReady;
    logic        iStart;
    logic [31:0] iA;
    logic [31:0] iB;
    logic [31:0] s_q;
    logic [4:0]  oS_address;
    logic [31:0] oA;
    logic [31:0] oB;
    logic        oBusy;
    logic        oValid;
`ifdef RC5_DECRYPT_EN
    logic        dec_in;
`endif

    logic [31:0] s_mem [0:25];

    int n_checks = 0;
    int n_fail   = 0;

    // S_RAM port B: address register lives in the DUT, so q follows the registered address.
    assign s_q = s_mem[oS_address];

    rc5_block_cipher #(.W(32), .R(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .iKeyReady  (iKeyReady),
        .iStart     (iStart),
        .iA         (iA),
        .iB         (iB),
`ifdef RC5_DECRYPT_EN
        .iDecrypt   (dec_in),
`endif
        .iS_sub_i   (s_q),
        .oS_address (oS_address),
        .oA         (oA),
        .oB         (oB),
        .oBusy      (oBusy),
        .oValid     (oValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
        if (n == 5'd0)
            return x;
        return (x << n) | (x >> (32 - int'(n)));
    endfunction

    task automatic expand_key(input logic [31:0] l0, l1, l2, l3);
        logic [31:0] l [4];
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] sum;
        int i;
        int j;
        l[0] = l0; l[1] = l1; l[2] = l2; l[3] = l3;
        s_mem[0] = 32'hB7E15163;
        for (int t = 1; t < 26; t++)
            s_mem[t] = s_mem[t-1] + 32'h9E3779B9;
        x = '0; y = '0; i = 0; j = 0;
        for (int n = 0; n < 78; n++) begin
            x = rotl32(s_mem[i] + x + y, 5'd3);
            s_mem[i] = x;
            sum = x + y;
            y = rotl32(l[j] + sum, sum[4:0]);
            l[j] = y;
            i = (i + 1) % 26;
            j = (j + 1) % 4;
        end
    endtask

    function automatic logic [63:0] ref_enc(input logic [31:0] a0, input logic [31:0] b0);
        logic [31:0] a;
        logic [31:0] b;
        a = a0 + s_mem[0];
        b = b0 + s_mem[1];
        for (int i = 1; i <= 12; i++) begin
            a = rotl32(a ^ b, b[4:0]) + s_mem[2*i];
            b = rotl32(b ^ a, a[4:0]) + s_mem[2*i+1];
        end
        return {a, b};
    endfunction

    task automatic run_block(input logic [31:0] a, input logic [31:0] b, input bit dec,
                             input int pulse_at, output int lat, output logic [31:0] ra,
                             output logic [31:0] rb, output int seq_err, output int vcnt);
        @(negedge clk);
        iA = a; iB = b; iStart = 1'b1;
`ifdef RC5_DECRYPT_EN
        dec_in = dec;
`endif
        @(negedge clk);
        iStart = 1'b0;
        lat = -1; ra = '0; rb = '0; seq_err = 0; vcnt = 0;
        for (int c = 1; c <= 45; c++) begin
            if (pulse_at > 0 && (c == pulse_at || c == pulse_at + 7)) begin
                iStart = 1'b1; iA = ~a;
            end else begin
                iStart = 1'b0; iA = a;
            end
            if (oValid) begin
                vcnt++;
                if (lat < 0) begin lat = c; ra = oA; rb = oB; end
            end
            if (c <= 26) begin
                if (!oBusy || oS_address != (dec ? 5'(26 - c) : 5'(c - 1)))
                    seq_err++;
            end else if (oBusy) begin
                seq_err++;
            end
            @(negedge clk);
        end
        iStart = 1'b0;
    endtask

    int          lat;
    int          seq_err;
    int          vcnt;
    int          bad;
    int          v1;
    int          v2;
    logic        busy11;
    logic        exp_busy;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] ra2;
    logic [31:0] rb2;
    logic [63:0] exp2;

    initial begin
        rst = 1'b0; iKeyReady = 1'b0; iStart = 1'b0; iA = '0; iB = '0;
`ifdef RC5_DECRYPT_EN
        dec_in = 1'b0;
`endif
        for (int t = 0; t < 26; t++) s_mem[t] = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_addr", 64'(oS_address), 0);
        check_eq("rst_a", 64'(oA), 0);
        check_eq("rst_b", 64'(oB), 0);
        check_eq("rst_busy", 64'(oBusy), 0);
        check_eq("rst_valid", 64'(oValid), 0);
        rst = 1'b1;
        @(negedge clk);

        bad = 0;
        iStart = 1'b1; iA = 32'h11111111; iB = 32'h22222222;
        repeat (6) begin
            @(negedge clk);
            if (oBusy || oValid || oS_address != 5'd0) bad++;
        end
        iStart = 1'b0;
        check_eq("nokey_ignored", 64'(bad), 0);

        expand_key(32'h0, 32'h0, 32'h0, 32'h0);
        iKeyReady = 1'b1;
        run_block(32'h0, 32'h0, 1'b0, 0, lat, ra, rb, seq_err, vcnt);
        check_eq("zk_latency", 64'(lat), 27);
        check_eq("zk_a", 64'(ra), 64'h0000_0000_EEDB_A521);
        check_eq("zk_b", 64'(rb), 64'h0000_0000_6D8F_4B15);
        check_eq("zk_addr_seq", 64'(seq_err), 0);
        check_eq("zk_valid_count", 64'(vcnt), 1);

`ifdef RC5_DECRYPT_EN
        run_block(32'hEEDBA521, 32'h6D8F4B15, 1'b1, 0, lat, ra, rb, seq_err, vcnt);
        check_eq("dec_latency", 64'(lat), 27);
        check_eq("dec_a", 64'(ra), 0);
        check_eq("dec_b", 64'(rb), 0);
        check_eq("dec_addr_seq", 64'(seq_err), 0);
        dec_in = 1'b0;
`endif

        iKeyReady = 1'b0;
        expand_key(32'h19465F91, 32'h51B241BE, 32'h01A55563, 32'h91CEA910);
        @(negedge clk);
        iKeyReady = 1'b1;
        run_block(32'hEEDBA521, 32'h6D8F4B15, 1'b0, 5, lat, ra, rb, seq_err, vcnt);
        check_eq("k2_latency", 64'(lat), 27);
        check_eq("k2_a", 64'(ra), 64'h0000_0000_AC13_C0F7);
        check_eq("k2_b", 64'(rb), 64'h0000_0000_5289_2B5B);
        check_eq("k2_pulses_ignored", 64'(seq_err), 0);
        check_eq("k2_valid_count", 64'(vcnt), 1);

        @(negedge clk);
        iA = 32'h01234567; iB = 32'h89ABCDEF; iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        vcnt = 0; busy11 = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            if (c == 10) iKeyReady = 1'b0;
            if (c == 11) busy11 = oBusy;
            if (oValid) vcnt++;
            @(negedge clk);
        end
        check_eq("abort_busy", 64'(busy11), 0);
        check_eq("abort_no_valid", 64'(vcnt), 0);
        check_eq("abort_hold_a", 64'(oA), 64'h0000_0000_AC13_C0F7);
        check_eq("abort_hold_b", 64'(oB), 64'h0000_0000_5289_2B5B);
        iKeyReady = 1'b1;

        @(negedge clk);
        iA = 32'h0BADF00D; iB = 32'hCAFEBABE; iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("pre_rst_addr", 64'(oS_address), 4);
        rst = 1'b0;
        #1;
        check_eq("midrst_a", 64'(oA), 0);
        check_eq("midrst_b", 64'(oB), 0);
        check_eq("midrst_busy", 64'(oBusy), 0);
        check_eq("midrst_addr", 64'(oS_address), 0);
        check_eq("midrst_valid", 64'(oValid), 0);
        @(negedge clk);
        rst = 1'b1;

        iKeyReady = 1'b0;
        expand_key(32'h0, 32'h0, 32'h0, 32'h0);
        exp2 = ref_enc(32'h12345678, 32'hFEDCBA98);
        @(negedge clk);
        iKeyReady = 1'b1;
        iA = '0; iB = '0; iStart = 1'b1;
        @(negedge clk);
        v1 = -1; v2 = -1; bad = 0; seq_err = 0;
        ra = '0; rb = '0; ra2 = '0; rb2 = '0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 10) begin iA = 32'h12345678; iB = 32'hFEDCBA98; end
            if (c == 56) iStart = 1'b0;
            if (oValid) begin
                if (v1 < 0) begin v1 = c; ra = oA; rb = oB; end
                else if (v2 < 0) begin v2 = c; ra2 = oA; rb2 = oB; end
                else bad++;
            end
            exp_busy = (c <= 26) || (c >= 29 && c <= 54);
            if (oBusy != exp_busy) seq_err++;
            if (c <= 26 && oS_address != 5'(c - 1)) seq_err++;
            if (c >= 29 && c <= 54 && oS_address != 5'(c - 29)) seq_err++;
            @(negedge clk);
        end
        check_eq("b2b_valid1_cycle", 64'(v1), 27);
        check_eq("b2b_valid2_cycle", 64'(v2), 55);
        check_eq("b2b_a1", 64'(ra), 64'h0000_0000_EEDB_A521);
        check_eq("b2b_b1", 64'(rb), 64'h0000_0000_6D8F_4B15);
        check_eq("b2b_a2", 64'(ra2), 64'(exp2[63:32]));
        check_eq("b2b_b2", 64'(rb2), 64'(exp2[31:0]));
        check_eq("b2b_busy_addr_seq", 64'(seq_err), 0);
        check_eq("b2b_extra_valid", 64'(bad), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
